// File: rtl/conv2d_sched.sv
// Conv2D job scheduler: weight reads, per-pixel halo-aware ifm window reads, one-entry result write buffer; comp_start one cycle after accepted start.
// Reads stall on rd_req_ready and are held off while the write buffer is full; optional CONV2D_SCHED_PERF_EN adds perf_cycles.
module conv2d_sched #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int WT_DIM = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              idle,
  output logic              done,
  input  logic [31:0]       fm_dim,
  input  logic [AWIDTH-1:0] wt_base,
  input  logic [AWIDTH-1:0] ifm_base,
  input  logic [AWIDTH-1:0] ofm_base,
  output logic              comp_start,
  output logic [31:0]       x,
  output logic [31:0]       y,
  output logic [31:0]       comp_fm_dim,
  input  logic [DWIDTH-1:0] comp_wdata,
  input  logic              comp_wdata_valid,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [AWIDTH-1:0] rd_req_addr,
  output logic              wr_req_valid,
  input  logic              wr_req_ready,
  output logic [AWIDTH-1:0] wr_req_addr,
  output logic [DWIDTH-1:0] wr_req_data
`ifdef CONV2D_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam int WT_SIZE = WT_DIM * WT_DIM;
  localparam int HALF    = WT_DIM / 2;
  localparam int CW      = $clog2(WT_SIZE + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_WT,
    RD_FM,
    WAIT_OUT,
    FLUSH,
    DONE
  } state_t;

  typedef struct packed {
    logic [31:0]       fm_dim;
    logic [AWIDTH-1:0] wt_base;
    logic [AWIDTH-1:0] ifm_base;
    logic [AWIDTH-1:0] ofm_base;
  } cfg_t;

  state_t            state, state_nxt;
  cfg_t              cfg;
  logic [CW-1:0]     k, m, n;
  logic              wbuf_full;

  logic              start_acc;
  logic              rd_hs;
  logic              wt_last;
  logic              cell_done;
  logic              cell_last;
  logic              capture;
  logic              last_pixel;
  logic              halo;
  logic signed [33:0] idx, idy, fm_dim_s;
  logic [63:0]       fm_lin, out_lin;
  logic [AWIDTH-1:0] wt_addr, fm_addr, out_addr;

  // Window coordinates relative to the current output pixel, kept signed so the
  // top/left halo shows up as negative.
  always_comb begin
    fm_dim_s = $signed({2'b00, cfg.fm_dim});
    idx      = $signed({2'b00, x}) + $signed(34'(n)) - 34'(HALF);
    idy      = $signed({2'b00, y}) + $signed(34'(m)) - 34'(HALF);
    halo     = idx[33] | idy[33] | (idx >= fm_dim_s) | (idy >= fm_dim_s);
    fm_lin   = 64'(idy[31:0]) * 64'(cfg.fm_dim) + 64'(idx[31:0]);
    out_lin  = 64'(y) * 64'(cfg.fm_dim) + 64'(x);
    fm_addr  = cfg.ifm_base + AWIDTH'(fm_lin << 2);
    out_addr = cfg.ofm_base + AWIDTH'(out_lin << 2);
    wt_addr  = cfg.wt_base + AWIDTH'({k, 2'b00});
  end

  assign start_acc   = (state == IDLE) & start;
  assign rd_hs       = rd_req_valid & rd_req_ready;
  assign wt_last     = (k == CW'(WT_SIZE - 1));
  assign cell_done   = (state == RD_FM) & (halo | rd_hs);
  assign cell_last   = (m == CW'(WT_DIM - 1)) & (n == CW'(WT_DIM - 1));
  assign capture     = (state == WAIT_OUT) & comp_wdata_valid;
  assign last_pixel  = (x == cfg.fm_dim - 32'd1) & (y == cfg.fm_dim - 32'd1);
  assign wr_req_valid = wbuf_full;
  assign comp_fm_dim  = cfg.fm_dim;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    idle         = 1'b0;
    done         = 1'b0;
    rd_req_valid = 1'b0;
    rd_req_addr  = '0;
    case (state)
      IDLE: begin
        idle = 1'b1;
        if (start) state_nxt = RD_WT;
      end
      RD_WT: begin
        rd_req_valid = 1'b1;
        rd_req_addr  = wt_addr;
        if (rd_hs && wt_last) state_nxt = RD_FM;
      end
      RD_FM: begin
        // A full write buffer blocks the center read, so compute cannot overrun it.
        rd_req_valid = ~halo & ~wbuf_full;
        rd_req_addr  = rd_req_valid ? fm_addr : '0;
        if (cell_done && cell_last) state_nxt = WAIT_OUT;
      end
      WAIT_OUT: begin
        if (comp_wdata_valid) state_nxt = last_pixel ? FLUSH : RD_FM;
      end
      FLUSH: begin
        if (!wbuf_full) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg         <= '0;
      k           <= '0;
      m           <= '0;
      n           <= '0;
      x           <= '0;
      y           <= '0;
      comp_start  <= 1'b0;
      wbuf_full   <= 1'b0;
      wr_req_addr <= '0;
      wr_req_data <= '0;
    end else begin
      comp_start <= start_acc;

      if (start_acc) begin
        cfg.fm_dim   <= fm_dim;
        cfg.wt_base  <= wt_base;
        cfg.ifm_base <= ifm_base;
        cfg.ofm_base <= ofm_base;
        k <= '0;
        m <= '0;
        n <= '0;
        x <= '0;
        y <= '0;
      end

      if (state == RD_WT && rd_hs) k <= wt_last ? '0 : k + CW'(1);

      if (cell_done) begin
        if (n == CW'(WT_DIM - 1)) begin
          n <= '0;
          m <= (m == CW'(WT_DIM - 1)) ? '0 : m + CW'(1);
        end else begin
          n <= n + CW'(1);
        end
      end

      if (capture) begin
        wr_req_addr <= out_addr;
        wr_req_data <= comp_wdata;
        m <= '0;
        n <= '0;
        if (!last_pixel) begin
          if (x == cfg.fm_dim - 32'd1) begin
            x <= '0;
            y <= y + 32'd1;
          end else begin
            x <= x + 32'd1;
          end
        end
      end

      if (capture)                        wbuf_full <= 1'b1;
      else if (wbuf_full && wr_req_ready) wbuf_full <= 1'b0;
    end
  end

`ifdef CONV2D_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 perf_cycles <= '0;
    else if (start_acc)      perf_cycles <= '0;
    else if (state != IDLE)  perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule
